// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types for the pipeline hazard controller
package pipeline_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SB_HOLD   = 2'd0,
    SB_SHIFT  = 2'd1,
    SB_BUBBLE = 2'd2,
    SB_CLEAR  = 2'd3
  } sb_op_t;

  // Register zero is hardwired, so it never produces a hazard.
  function automatic logic sb_hit(input sb_entry_t ex, input sb_entry_t mem,
                                  input logic [REG_AW-1:0] r);
    return (r != '0) && ((ex.valid && ex.dest == r) || (mem.valid && mem.dest == r));
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX/MEM destination scoreboard with source-register compare
module hazard_scoreboard
  import pipeline_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  sb_op_t            op,
  input  logic              new_valid,
  input  logic [REG_AW-1:0] new_dest,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              hit_rs,
  output logic              hit_rt
);

  sb_entry_t sb_ex;
  sb_entry_t sb_mem;

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_ex  <= '0;
      sb_mem <= '0;
    end else begin
      case (op)
        SB_SHIFT: begin
          sb_mem <= sb_ex;
          sb_ex  <= '{valid: new_valid, dest: new_dest};
        end
        SB_BUBBLE: begin
          sb_mem <= sb_ex;
          sb_ex  <= '0;
        end
        SB_CLEAR: begin
          sb_ex  <= '0;
          sb_mem <= '0;
        end
        default: begin
          sb_ex  <= sb_ex;
          sb_mem <= sb_mem;
        end
      endcase
    end
  end

  assign hit_rs = sb_hit(sb_ex, sb_mem, rs);
  assign hit_rt = sb_hit(sb_ex, sb_mem, rt);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW stall, branch flush and debug halt sequencing
// Optional performance counters enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_writes,
  input  logic              mem_branch_taken,
  input  logic              halt_req,
  input  logic              step_req,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              pipe_en,
  output logic              stall,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt,
`endif
  output logic              halted
);

  import pipeline_pkg::*;

  state_t state;
  state_t next_state;
  sb_op_t sb_op;
  logic   hit_rs;
  logic   hit_rt;
  logic   raw;
  logic   branch_flush;

  hazard_scoreboard u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .op        (sb_op),
    .new_valid (id_valid && id_writes && (id_dest != '0)),
    .new_dest  (id_dest),
    .rs        (id_rs),
    .rt        (id_rt),
    .hit_rs    (hit_rs),
    .hit_rt    (hit_rt)
  );

  assign raw = id_valid && ((id_uses_rs && hit_rs) || (id_uses_rt && hit_rt));

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    sb_op        = SB_HOLD;
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    pipe_en      = 1'b0;
    stall        = 1'b0;
    halted       = 1'b0;
    branch_flush = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      sb_op       = SB_CLEAR;
      next_state  = RUN;
    end else begin
      // A taken branch squashes EX, ID and IF, so it outranks any RAW stall.
      if (state != HALTED) begin
        pipe_en = 1'b1;
        if (mem_branch_taken) begin
          pc_we        = 1'b1;
          ifid_we      = 1'b1;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          exmem_flush  = 1'b1;
          sb_op        = SB_CLEAR;
          branch_flush = 1'b1;
        end else if (raw) begin
          idex_flush = 1'b1;
          stall      = 1'b1;
          sb_op      = SB_BUBBLE;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          sb_op   = SB_SHIFT;
        end
      end
      case (state)
        RUN:     if (halt_req) next_state = HALTED;
        HALTED: begin
          halted = 1'b1;
          if (!halt_req)     next_state = RUN;
          else if (step_req) next_state = STEP;
        end
        STEP:    next_state = halt_req ? HALTED : RUN;
        default: next_state = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // stall and branch_flush are only raised in active cycles, so HALTED never counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (branch_flush && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks against a behavioural model
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
  localparam int PW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic [AW-1:0] id_dest;
  logic          id_writes;
  logic          mem_branch_taken;
  logic          halt_req;
  logic          step_req;
  logic          pc_we;
  logic          ifid_we;
  logic          ifid_flush;
  logic          idex_flush;
  logic          exmem_flush;
  logic          pipe_en;
  logic          stall;
  logic          halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [PW-1:0] perf_stall_cnt;
  logic [PW-1:0] perf_flush_cnt;
`endif

  pipeline_hazard_ctrl #(.REG_AW(AW), .PERF_W(PW)) dut (
    .clock            (clock),
    .reset            (reset),
    .id_valid         (id_valid),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rs       (id_uses_rs),
    .id_uses_rt       (id_uses_rt),
    .id_dest          (id_dest),
    .id_writes        (id_writes),
    .mem_branch_taken (mem_branch_taken),
    .halt_req         (halt_req),
    .step_req         (step_req),
    .pc_we            (pc_we),
    .ifid_we          (ifid_we),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .exmem_flush      (exmem_flush),
    .pipe_en          (pipe_en),
    .stall            (stall),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_flush_cnt   (perf_flush_cnt),
`endif
    .halted           (halted)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: destinations in flight in EX and MEM (0 = nothing to wait for).
  int m_ex;
  int m_mem;
  bit m_halted;
  bit m_step;
  int m_stalls;
  int m_flushes;

  // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_en, stall, halted}
  logic [7:0] obs;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic bit reads_pending(input logic uses, input logic [AW-1:0] r);
    return uses && (r != 0) && ((int'(r) == m_ex) || (int'(r) == m_mem));
  endfunction

  function automatic bit model_raw();
    return id_valid && (reads_pending(id_uses_rs, id_rs) || reads_pending(id_uses_rt, id_rt));
  endfunction

  function automatic logic [7:0] expect_out();
    if (reset)            return 8'b0011_1000;
    if (m_halted)         return 8'b0000_0001;
    if (mem_branch_taken) return 8'b1111_1100;
    if (model_raw())      return 8'b0001_0110;
    return 8'b1100_0100;
  endfunction

  task automatic update_model();
    if (reset) begin
      m_ex = 0; m_mem = 0; m_halted = 0; m_step = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!m_halted) begin
        if (mem_branch_taken) begin
          m_ex = 0; m_mem = 0; m_flushes++;
        end else if (model_raw()) begin
          m_mem = m_ex; m_ex = 0; m_stalls++;
        end else begin
          m_mem = m_ex;
          m_ex  = (id_valid && id_writes) ? int'(id_dest) : 0;
        end
      end
      if (m_step)         begin m_step = 0; m_halted = halt_req; end
      else if (!m_halted) m_halted = halt_req;
      else if (!halt_req) m_halted = 0;
      else if (step_req)  begin m_halted = 0; m_step = 1; end
    end
  endtask

  task automatic tick(input string tag);
    #3;
    obs = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_en, stall, halted};
    chk(tag, obs, expect_out());
    @(posedge clock);
    update_model();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic urs,
                        input logic [AW-1:0] rt, input logic urt,
                        input logic [AW-1:0] d, input logic w);
    id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_dest = d; id_writes = w;
  endtask

  initial begin
    reset = 1'b1; mem_branch_taken = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    m_ex = 0; m_mem = 0; m_halted = 0; m_step = 0; m_stalls = 0; m_flushes = 0;
    @(posedge clock); #1;

    tick("reset0");
    chk("reset_vec", obs, 8'h38);
    tick("reset1");
    reset = 1'b0;

    // back-to-back dependence
    set_id(1, 0, 0, 0, 0, 5, 1); tick("b2b_c0");
    set_id(1, 5, 1, 0, 0, 0, 0); tick("b2b_c1");
    chk("b2b_c1_stall", obs[1], 1); chk("b2b_c1_pcwe", obs[7], 0); chk("b2b_c1_idex", obs[4], 1);
    tick("b2b_c2");
    chk("b2b_c2_stall", obs[1], 1); chk("b2b_c2_pcwe", obs[7], 0);
    tick("b2b_c3");
    chk("b2b_c3_stall", obs[1], 0); chk("b2b_c3_pcwe", obs[7], 1);

    // register zero never hazards
    set_id(1, 0, 0, 0, 0, 0, 1); tick("r0_prod");
    set_id(1, 0, 1, 0, 1, 0, 0); tick("r0_cons");
    chk("r0_stall", obs[1], 0);

    // taken branch during a RAW stall
    set_id(1, 0, 0, 0, 0, 7, 1); tick("br_prod");
    set_id(1, 7, 1, 0, 0, 0, 0); mem_branch_taken = 1'b1; tick("br_hit");
    chk("br_vec", obs, 8'hFC);
    mem_branch_taken = 1'b0; tick("br_after");
    chk("br_after_stall", obs[1], 0); chk("br_after_pcwe", obs[7], 1);

    // halt / single step
    set_id(0, 0, 0, 0, 0, 0, 0); halt_req = 1'b1; tick("halt_req");
    chk("halt_first_active", obs[7], 1);
    tick("halted0"); chk("halted0_vec", obs, 8'h01);
    step_req = 1'b1; tick("step_req"); chk("step_req_vec", obs, 8'h01);
    step_req = 1'b0; tick("step_cycle");
    chk("step_pcwe", obs[7], 1); chk("step_pipe_en", obs[2], 1);
    tick("rehalted"); chk("rehalted_vec", obs, 8'h01);
    halt_req = 1'b0; tick("release"); chk("release_vec", obs, 8'h01);
    tick("run_again"); chk("run_again_halted", obs[0], 0);

    // reset in the middle of a stall
    set_id(1, 0, 0, 0, 0, 5, 1); tick("rst_prod");
    set_id(1, 5, 1, 0, 0, 0, 0); tick("rst_stall"); chk("rst_stall_on", obs[1], 1);
    reset = 1'b1; tick("rst_mid"); chk("rst_mid_vec", obs, 8'h38);
    reset = 1'b0; tick("rst_after"); chk("rst_after_stall", obs[1], 0);

`ifdef HAZARD_PERF_CNT_EN
    reset = 1'b1; set_id(0, 0, 0, 0, 0, 0, 0); tick("perf_rst");
    reset = 1'b0;
    set_id(1, 0, 0, 0, 0, 5, 1); tick("perf_p5");
    set_id(1, 5, 1, 0, 0, 6, 1); tick("perf_s1"); tick("perf_s2"); tick("perf_go");
    set_id(1, 6, 1, 0, 0, 0, 0); tick("perf_s3");
    mem_branch_taken = 1'b1; tick("perf_br");
    mem_branch_taken = 1'b0; halt_req = 1'b1;
    for (int i = 0; i < 4; i++) tick("perf_halt");
    halt_req = 1'b0; tick("perf_release");
    chk("perf_stall_cnt", perf_stall_cnt, 3);
    chk("perf_flush_cnt", perf_flush_cnt, 1);
`endif

    // randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 199) == 0);
      mem_branch_taken = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      step_req         = ($urandom_range(0, 3) == 0);
      set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom));
      tick("rand");
    end

`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_rand", perf_stall_cnt, m_stalls);
    chk("perf_flush_rand", perf_flush_cnt, m_flushes);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the five-stage pipeline (IF/ID/EX/MEM/WB).
- Keeps a 2-entry destination-register scoreboard covering the EX and MEM stages and detects RAW hazards at ID.
- Drives the stall enables, bubble and flush controls for the PC and the pipeline registers.
- Implements predict-not-taken branch recovery (branches resolve in MEM) and a debug halt/single-step FSM that freezes the whole datapath.

Parameters:
- REG_AW, 5, register address width.
- PERF_W, 16, width of the optional performance counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_AW  rs field of the ID instruction
- id_rt  in  REG_AW  rt field of the ID instruction
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_dest  in  REG_AW  destination register of the ID instruction
- id_writes  in  1  ID instruction writes the register file
- mem_branch_taken  in  1  branch in MEM resolved taken (EX/MEM Cond AND CS_Branch)
- halt_req  in  1  level; debug halt request
- step_req  in  1  pulse; advance one cycle while halted
- pc_we  out  1  PC update enable
- ifid_we  out  1  IF/ID register load enable
- ifid_flush  out  1  clear IF/ID to a bubble
- idex_flush  out  1  clear ID/EX to a bubble
- exmem_flush  out  1  clear EX/MEM to a bubble
- pipe_en  out  1  global enable for ID/EX, EX/MEM, MEM/WB, register write and memory write
- stall  out  1  RAW stall active this cycle
- halted  out  1  FSM is in HALTED

Behaviour:
- Decided: one clock, port "clock"; reset is synchronous and active-high, port "reset".
- FSM states: RUN, HALTED, STEP. Scoreboard entries: sb_ex and sb_mem, each {valid, dest}.
- Outputs are combinational from FSM state, scoreboard and current inputs. FSM and scoreboard are registered.
- While reset=1:
  - pc_we=0, ifid_we=0, pipe_en=0.
  - ifid_flush=1, idex_flush=1, exmem_flush=1.
  - stall=0, halted=0.
  - Next state RUN; scoreboard cleared.
- hit(r) = r!=0 AND ((sb_ex.valid AND sb_ex.dest==r) OR (sb_mem.valid AND sb_mem.dest==r)).
  - The WB stage is excluded: the register file is double-bumped (write first half, read second half).
- raw = id_valid AND ((id_uses_rs AND hit(id_rs)) OR (id_uses_rt AND hit(id_rt))).
- Active cycle (state RUN, or STEP) takes priority in this order:
  1. mem_branch_taken=1:
     - pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1, exmem_flush=1, pipe_en=1, stall=0.
     - Next sb_ex and sb_mem are both invalid, because the instructions in EX, ID and IF are squashed.
     - raw is ignored.
  2. raw=1:
     - pc_we=0, ifid_we=0, idex_flush=1 (bubble), pipe_en=1, stall=1.
     - Next sb_mem = sb_ex; next sb_ex invalid.
  3. Otherwise:
     - pc_we=1, ifid_we=1, pipe_en=1, all flushes 0.
     - Next sb_mem = sb_ex.
     - Next sb_ex = {id_valid AND id_writes AND id_dest!=0, id_dest}.
- HALTED:
  - pc_we=0, ifid_we=0, pipe_en=0, all flushes 0, stall=0, halted=1.
  - Scoreboard holds its value.
  - mem_branch_taken is not acted on until the next active cycle; the datapath holds it because EX/MEM is frozen.
- Transitions:
  - RUN -> HALTED when halt_req=1. The current cycle still completes as an active cycle.
  - HALTED -> STEP when step_req=1 and halt_req=1.
  - HALTED -> RUN when halt_req=0. halt_req=0 takes priority over step_req.
  - STEP -> HALTED if halt_req=1, otherwise -> RUN.
- A step_req pulse in RUN or STEP is ignored.
- A RAW stall persists across cycles until the producer leaves MEM: at most 2 stall cycles per consumer.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined:
  - Extra outputs perf_stall_cnt[PERF_W-1:0] (counts RAW stall cycles) and perf_flush_cnt[PERF_W-1:0] (counts taken-branch flushes).
  - Both are cleared by reset, saturate at all-ones and do not count while HALTED.
- When undefined: the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - REG_AW.
  - The FSM state encoding: RUN=2'd0, HALTED=2'd1, STEP=2'd2.
  - The scoreboard entry struct {valid, dest}.
- One sub-module, hazard_scoreboard: holds the two entries, implements the shift/clear/hold controls and the combinational hit() compare for both source ports.
- The FSM and output priority logic stay in the top module.

Test Plan:
- Back-to-back dependence: id_dest=5, id_writes=1 at cycle 0; cycle 1 reads rs=5 -> stall=1, pc_we=0, idex_flush=1 on cycles 1 and 2; stall=0 and pc_we=1 on cycle 3.
- Register zero: producer id_dest=0, consumer reads rs=0 -> stall never asserts; sb_ex.valid stays 0.
- Taken branch during a RAW stall: raw=1 and mem_branch_taken=1 in the same cycle -> ifid_flush=idex_flush=exmem_flush=1, pc_we=1, stall=0; next cycle scoreboard empty and no stall.
- Halt/step: halt_req=1 -> halted=1 from the next cycle with all enables 0; one step_req pulse -> exactly one cycle with pc_we=1 and pipe_en=1, then halted=1 again; halt_req=0 -> RUN.
- Reset mid-stall: reset during a RAW stall -> all three flushes 1 and pc_we=0 that cycle; after reset, a consumer of rs=5 does not stall.
- With HAZARD_PERF_CNT_EN: 3 RAW stall cycles and 1 taken branch -> perf_stall_cnt=3, perf_flush_cnt=1; cycles spent in HALTED add nothing.
